// File: rtl/audio_fetch.sv
// audio_fetch: round-robin, slot-gated per-channel sample fetch from VRAM/TILE memory
module audio_fetch #(
    parameter int CHANNELS    = 1,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic                     audio_enable_i,
    input  logic                     dma_slot_i,
    input  logic [CHANNELS-1:0]      chan_fetch_i,
    input  logic [CHANNELS*16-1:0]   chan_addr_i,
    input  logic [CHANNELS-1:0]      chan_tile_i,
    output logic [CHANNELS*16-1:0]   chan_word_o,
    output logic                     mem_sel_o,
    output logic                     mem_tile_o,
    output logic [15:0]              mem_addr_o,
    input  logic                     mem_ack_i,
    input  logic [15:0]              mem_data_i,
    output logic                     busy_o,
    output logic [CHANNELS-1:0]      underrun_o,
    input  logic                     underrun_clr_i
);
    localparam int PW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
    state_t state;
    logic [CHANNELS-1:0] fetch_prev, pending, cap_tile, rise, fin;
    logic [15:0] cap_addr [CHANNELS];
    logic [PW-1:0] rr_ptr, gnt, pick;
    logic [7:0] timer;
    logic [15:0] pick_addr;
    logic found, pick_tile, done, timeout;
    int best;
    assign rise = chan_fetch_i & ~fetch_prev;
    assign done = state == REQ && (mem_ack_i || timer == 8'd0);
    assign timeout = done && !mem_ack_i;
    assign busy_o = state == REQ;
    // pick the pending channel with the smallest round-robin distance from rr_ptr
    always_comb begin
        found = 1'b0;
        pick = '0;
        pick_addr = '0;
        pick_tile = 1'b0;
        best = CHANNELS;
        fin = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            fin[n] = done && gnt == PW'(n);
            if (pending[n] && (n - int'(rr_ptr) + CHANNELS) % CHANNELS < best) begin
                best = (n - int'(rr_ptr) + CHANNELS) % CHANNELS;
                found = 1'b1;
                pick = PW'(n);
                pick_addr = cap_addr[n];
                pick_tile = cap_tile[n];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state <= IDLE;
            fetch_prev <= '0;
            pending <= '0;
            cap_tile <= '0;
            rr_ptr <= '0;
            gnt <= '0;
            timer <= '0;
            mem_sel_o <= 1'b0;
            mem_addr_o <= '0;
            mem_tile_o <= 1'b0;
            chan_word_o <= '0;
            underrun_o <= '0;
            for (int n = 0; n < CHANNELS; n++) cap_addr[n] <= '0;
        end else begin
            fetch_prev <= chan_fetch_i;
            for (int n = 0; n < CHANNELS; n++) begin
                pending[n] <= audio_enable_i && (rise[n] || (pending[n] && !fin[n]));
                if (audio_enable_i && rise[n]) begin
                    cap_addr[n] <= chan_addr_i[16*n +: 16];
                    cap_tile[n] <= chan_tile_i[n];
                end
                underrun_o[n] <= (audio_enable_i && rise[n] && pending[n]) || (timeout && fin[n]) ||
                                 (underrun_o[n] && !underrun_clr_i);
                if (state == REQ && mem_ack_i && gnt == PW'(n)) chan_word_o[16*n +: 16] <= mem_data_i;
            end
            case (state)
                IDLE: if (audio_enable_i && dma_slot_i && found) begin
                    gnt <= pick;
                    mem_addr_o <= pick_addr;
                    mem_tile_o <= pick_tile;
                    mem_sel_o <= 1'b1;
                    timer <= 8'(ACK_TIMEOUT);
                    state <= REQ;
                end
                REQ: if (done) begin
                    mem_sel_o <= 1'b0;
                    rr_ptr <= gnt == PW'(CHANNELS - 1) ? '0 : gnt + 1'b1;
                    state <= GAP;
                end else begin
                    timer <= timer - 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_fetch.sv
// tb_audio_fetch: directed plus randomized checks of audio_fetch against a behavioural model
module tb_audio_fetch;
    localparam int C = 4;
    localparam int TO = 15;
    logic clk = 1'b0;
    logic reset_i = 1'b1, audio_enable_i = 1'b1, dma_slot_i = 1'b1, mem_ack_i = 1'b0, underrun_clr_i = 1'b0;
    logic [C-1:0] chan_fetch_i = '0, chan_tile_i = '0, underrun_o;
    logic [C*16-1:0] chan_addr_i = '0, chan_word_o;
    logic [15:0] mem_data_i = '0, mem_addr_o;
    logic mem_sel_o, mem_tile_o, busy_o;
    int n_cmp = 0, n_bad = 0;

    audio_fetch #(.CHANNELS(C), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset_i(reset_i), .audio_enable_i(audio_enable_i), .dma_slot_i(dma_slot_i),
        .chan_fetch_i(chan_fetch_i), .chan_addr_i(chan_addr_i), .chan_tile_i(chan_tile_i),
        .chan_word_o(chan_word_o), .mem_sel_o(mem_sel_o), .mem_tile_o(mem_tile_o),
        .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .busy_o(busy_o), .underrun_o(underrun_o), .underrun_clr_i(underrun_clr_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model: transaction rules evaluated once per clock
    logic [C-1:0] m_prev, m_pend, m_tile, m_und;
    logic [15:0] m_addr [C];
    logic [C*16-1:0] m_word;
    logic [15:0] m_maddr;
    logic m_sel, m_mtile;
    int m_rr, m_phase, m_srv, m_reqn;

    task automatic model();
        logic [C-1:0] rise;
        int g;
        bit fin, tmo;
        rise = chan_fetch_i & ~m_prev;
        if (reset_i) begin
            m_prev = '0; m_pend = '0; m_tile = '0; m_und = '0; m_word = '0;
            m_maddr = '0; m_sel = 0; m_mtile = 0; m_rr = 0; m_phase = 0; m_srv = 0; m_reqn = 0;
            for (int n = 0; n < C; n++) m_addr[n] = '0;
            return;
        end
        g = -1;
        if (m_phase == 0 && audio_enable_i && dma_slot_i)
            for (int k = 0; k < C; k++)
                if (g < 0 && m_pend[(m_rr + k) % C]) g = (m_rr + k) % C;
        fin = m_phase == 1 && (mem_ack_i || m_reqn == TO + 1);
        tmo = fin && !mem_ack_i;
        for (int n = 0; n < C; n++) begin
            if ((audio_enable_i && rise[n] && m_pend[n]) || (tmo && n == m_srv)) m_und[n] = 1'b1;
            else if (underrun_clr_i) m_und[n] = 1'b0;
        end
        if (m_phase == 1 && mem_ack_i) m_word[16*m_srv +: 16] = mem_data_i;
        for (int n = 0; n < C; n++)
            m_pend[n] = audio_enable_i && (rise[n] || (m_pend[n] && !(fin && n == m_srv)));
        if (g >= 0) begin
            m_srv = g; m_maddr = m_addr[g]; m_mtile = m_tile[g]; m_sel = 1; m_phase = 1; m_reqn = 1;
        end else if (m_phase == 1) begin
            if (fin) begin m_sel = 0; m_phase = 2; m_rr = (m_srv + 1) % C; end
            else m_reqn++;
        end else if (m_phase == 2) m_phase = 0;
        for (int n = 0; n < C; n++)
            if (audio_enable_i && rise[n]) begin
                m_addr[n] = chan_addr_i[16*n +: 16];
                m_tile[n] = chan_tile_i[n];
            end
        m_prev = chan_fetch_i;
    endtask

    task automatic step();
        @(posedge clk);
        model();
        #1;
        check("sel", mem_sel_o, m_sel);
        check("addr", mem_addr_o, m_maddr);
        check("tile", mem_tile_o, m_mtile);
        check("busy", busy_o, m_phase == 1);
        check("word", chan_word_o, m_word);
        check("underrun", underrun_o, m_und);
    endtask

    task automatic wait_sel(input string tag);
        int k = 0;
        while (!mem_sel_o && k < 50) begin step(); k++; end
        check({tag, "_sel"}, mem_sel_o, 1);
    endtask

    task automatic ack(input logic [15:0] d);
        mem_ack_i = 1; mem_data_i = d;
        step();
        mem_ack_i = 0;
    endtask

    task automatic rise_on(input int ch, input logic [15:0] a, input logic t);
        chan_fetch_i[ch] = 1; chan_addr_i[16*ch +: 16] = a; chan_tile_i[ch] = t;
        step();
        chan_fetch_i[ch] = 0;
    endtask

    initial begin
        int cnt;
        repeat (2) step();
        reset_i = 0;
        step();
        check("rst_word", chan_word_o, 0);
        check("rst_und", underrun_o, 0);
        // basic fetch
        rise_on(0, 16'h1234, 0);
        wait_sel("basic");
        check("basic_addr", mem_addr_o, 16'h1234);
        check("basic_tile", mem_tile_o, 0);
        ack(16'hBEEF);
        check("basic_sel_1cyc", mem_sel_o, 0);
        check("basic_word", chan_word_o[15:0], 16'hBEEF);
        check("basic_und", underrun_o, 0);
        repeat (3) step();
        // slot gating
        dma_slot_i = 0;
        rise_on(0, 16'h5555, 1);
        cnt = 0;
        repeat (20) begin step(); cnt += mem_sel_o; end
        check("gate_quiet", cnt, 0);
        dma_slot_i = 1;
        step();
        check("gate_sel", mem_sel_o, 1);
        check("gate_addr", mem_addr_o, 16'h5555);
        ack(16'h0A0A);
        // round robin from a fresh reset
        reset_i = 1; step(); reset_i = 0;
        chan_fetch_i = 4'b0101; chan_addr_i[15:0] = 16'h0100; chan_addr_i[47:32] = 16'h0200;
        step();
        chan_fetch_i = 0;
        wait_sel("rr0");
        check("rr0_addr", mem_addr_o, 16'h0100);
        ack(16'h1111);
        wait_sel("rr2");
        check("rr2_addr", mem_addr_o, 16'h0200);
        rise_on(0, 16'h0300, 0);
        ack(16'h2222);
        wait_sel("rr0b");
        check("rr0b_addr", mem_addr_o, 16'h0300);
        ack(16'h3333);
        check("rr_und", underrun_o, 0);
        step();
        // timeout
        rise_on(0, 16'h0444, 0);
        wait_sel("to");
        cnt = 0;
        while (mem_sel_o && cnt < 40) begin cnt++; step(); end
        check("to_cycles", cnt, 16);
        check("to_und", underrun_o[0], 1);
        check("to_word", chan_word_o[15:0], 16'h3333);
        step();
        check("to_busy", busy_o, 0);
        underrun_clr_i = 1; step(); underrun_clr_i = 0;
        check("clr_und", underrun_o, 0);
        // overrun
        dma_slot_i = 0;
        rise_on(1, 16'h0010, 0);
        step();
        rise_on(1, 16'h0020, 0);
        check("ovr_und", underrun_o[1], 1);
        dma_slot_i = 1;
        wait_sel("ovr");
        check("ovr_addr", mem_addr_o, 16'h0020);
        ack(16'h4444);
        cnt = 0;
        repeat (10) begin step(); cnt += mem_sel_o; end
        check("ovr_one_read", cnt, 0);
        underrun_clr_i = 1; step(); underrun_clr_i = 0;
        // disable mid-read
        rise_on(3, 16'h0777, 1);
        wait_sel("dis");
        audio_enable_i = 0;
        repeat (3) step();
        ack(16'hCAFE);
        check("dis_word", chan_word_o[63:48], 16'hCAFE);
        chan_fetch_i[2] = 1;
        cnt = 0;
        repeat (10) begin step(); cnt += mem_sel_o; end
        check("dis_ignored", cnt, 0);
        chan_fetch_i = 0; step();
        audio_enable_i = 1;
        // reset mid-read
        rise_on(1, 16'h0ABC, 1);
        wait_sel("rstm");
        reset_i = 1; step(); reset_i = 0;
        check("rstm_sel", mem_sel_o, 0);
        check("rstm_addr", mem_addr_o, 0);
        check("rstm_tile", mem_tile_o, 0);
        check("rstm_word", chan_word_o, 0);
        check("rstm_busy", busy_o, 0);
        check("rstm_und", underrun_o, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset_i = $urandom_range(0, 499) == 0;
            audio_enable_i = $urandom_range(0, 15) != 0;
            dma_slot_i = $urandom_range(0, 2) != 0;
            chan_fetch_i ^= C'($urandom_range(0, 15)) & C'($urandom_range(0, 15));
            chan_addr_i = {$urandom, $urandom};
            chan_tile_i = C'($urandom_range(0, 15));
            underrun_clr_i = $urandom_range(0, 19) == 0;
            mem_ack_i = m_sel && $urandom_range(0, 3) == 0;
            mem_data_i = 16'($urandom);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
